// File: rtl/ex_stage_if.sv
// ID/EX operand/control bundle, write-back bypass inputs and EX/MEM register outputs.
// master drives the ID/EX side and observes EX/MEM; slave is the execute stage itself.
interface ex_stage_if;
    localparam int unsigned DW = 8;
    localparam int unsigned RW = 3;

    logic          enb;
    logic          flush;
    logic [DW-1:0] r1;
    logic [DW-1:0] r2;
    logic [DW-1:0] const_disp;
    logic [2:0]    sc;
    logic [RW-1:0] dest;
    logic [RW-1:0] r1Address;
    logic [RW-1:0] r2Address;
    logic [3:0]    aluFunction;
    logic          AluInputBSel;
    logic          DMMemWrite;
    logic          regWrite;
    logic          regWriteDataSel;
    logic          Zenb;
    logic          Cenb;
    logic          wb_regWrite;
    logic [RW-1:0] wb_dest;
    logic [DW-1:0] wb_data;

    logic [DW-1:0] mem_aluResult;
    logic [DW-1:0] mem_storeData;
    logic [RW-1:0] mem_dest;
    logic          mem_DMMemWrite;
    logic          mem_regWrite;
    logic          mem_regWriteDataSel;
    logic          zFlag;
    logic          cFlag;

    modport master (
        output enb, flush, r1, r2, const_disp, sc, dest, r1Address, r2Address,
               aluFunction, AluInputBSel, DMMemWrite, regWrite, regWriteDataSel,
               Zenb, Cenb, wb_regWrite, wb_dest, wb_data,
        input  mem_aluResult, mem_storeData, mem_dest, mem_DMMemWrite,
               mem_regWrite, mem_regWriteDataSel, zFlag, cFlag
    );

    modport slave (
        input  enb, flush, r1, r2, const_disp, sc, dest, r1Address, r2Address,
               aluFunction, AluInputBSel, DMMemWrite, regWrite, regWriteDataSel,
               Zenb, Cenb, wb_regWrite, wb_dest, wb_data,
        output mem_aluResult, mem_storeData, mem_dest, mem_DMMemWrite,
               mem_regWrite, mem_regWriteDataSel, zFlag, cFlag
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, 8-bit ALU with Z/C flags, and the EX/MEM pipeline register.
// Flags live here so ADC/SBC see the previous instruction's carry one cycle later.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    ex_stage_if.slave   bus
);
    localparam int unsigned DW = 8;
    localparam int unsigned RW = 3;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_ADC = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_SBC = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_ANN = 4'h7;
    localparam logic [3:0] OP_SHL = 4'h8;
    localparam logic [3:0] OP_SHR = 4'h9;
    localparam logic [3:0] OP_ROL = 4'hA;
    localparam logic [3:0] OP_ROR = 4'hB;
    localparam logic [3:0] OP_PSB = 4'hC;

    logic [DW-1:0]   res_q;
    logic [DW-1:0]   store_q;
    logic [RW-1:0]   dest_q;
    logic            dm_q;
    logic            rw_q;
    logic            sel_q;
    logic            z_q;
    logic            c_q;

    logic            mem_fwd_ok;
    logic [DW-1:0]   fwd_a;
    logic [DW-1:0]   fwd_r2;
    logic [DW-1:0]   alu_b;
    logic [DW-1:0]   result;
    logic            cout;
    logic            has_cout;
    logic [DW:0]     sum;
    logic [2*DW-1:0] sh;

    // Loads in EX/MEM have no data yet, so they are never a bypass source.
    assign mem_fwd_ok = rw_q & ~sel_q;

    always_comb begin
        fwd_a = bus.r1;
        if (mem_fwd_ok && (dest_q == bus.r1Address)) begin
            fwd_a = res_q;
        end else if (bus.wb_regWrite && (bus.wb_dest == bus.r1Address)) begin
            fwd_a = bus.wb_data;
        end
    end

    always_comb begin
        fwd_r2 = bus.r2;
        if (mem_fwd_ok && (dest_q == bus.r2Address)) begin
            fwd_r2 = res_q;
        end else if (bus.wb_regWrite && (bus.wb_dest == bus.r2Address)) begin
            fwd_r2 = bus.wb_data;
        end
    end

    assign alu_b = bus.AluInputBSel ? bus.const_disp : fwd_r2;

    // Subtraction borrow falls out as bit 8 of the 9-bit wrapped difference.
    always_comb begin
        result   = fwd_a;
        cout     = 1'b0;
        has_cout = 1'b0;
        sum      = '0;
        sh       = '0;
        case (bus.aluFunction)
            OP_ADD: begin
                sum      = {1'b0, fwd_a} + {1'b0, alu_b};
                result   = sum[DW-1:0];
                cout     = sum[DW];
                has_cout = 1'b1;
            end
            OP_ADC: begin
                sum      = {1'b0, fwd_a} + {1'b0, alu_b} + (DW+1)'(c_q);
                result   = sum[DW-1:0];
                cout     = sum[DW];
                has_cout = 1'b1;
            end
            OP_SUB: begin
                sum      = {1'b0, fwd_a} - {1'b0, alu_b};
                result   = sum[DW-1:0];
                cout     = sum[DW];
                has_cout = 1'b1;
            end
            OP_SBC: begin
                sum      = {1'b0, fwd_a} - {1'b0, alu_b} - (DW+1)'(c_q);
                result   = sum[DW-1:0];
                cout     = sum[DW];
                has_cout = 1'b1;
            end
            OP_AND: result = fwd_a & alu_b;
            OP_OR:  result = fwd_a | alu_b;
            OP_XOR: result = fwd_a ^ alu_b;
            OP_ANN: result = fwd_a & ~alu_b;
            OP_SHL: begin
                sh       = {{DW{1'b0}}, fwd_a} << bus.sc;
                result   = sh[DW-1:0];
                cout     = sh[DW];
                has_cout = (bus.sc != 3'd0);
            end
            OP_SHR: begin
                sh       = {fwd_a, {DW{1'b0}}} >> bus.sc;
                result   = sh[2*DW-1:DW];
                cout     = sh[DW-1];
                has_cout = (bus.sc != 3'd0);
            end
            OP_ROL: begin
                sh     = {fwd_a, fwd_a} << bus.sc;
                result = sh[2*DW-1:DW];
            end
            OP_ROR: begin
                sh     = {fwd_a, fwd_a} >> bus.sc;
                result = sh[DW-1:0];
            end
            OP_PSB:  result = alu_b;
            default: result = fwd_a;
        endcase
    end

    // Flush wins over enable and only kills the side-effecting controls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q   <= '0;
            store_q <= '0;
            dest_q  <= '0;
            dm_q    <= 1'b0;
            rw_q    <= 1'b0;
            sel_q   <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
        end else if (bus.flush) begin
            rw_q <= 1'b0;
            dm_q <= 1'b0;
        end else if (bus.enb) begin
            res_q   <= result;
            store_q <= fwd_r2;
            dest_q  <= bus.dest;
            dm_q    <= bus.DMMemWrite;
            rw_q    <= bus.regWrite;
            sel_q   <= bus.regWriteDataSel;
            if (bus.Zenb) begin
                z_q <= (result == '0);
            end
            if (bus.Cenb && has_cout) begin
                c_q <= cout;
            end
        end
    end

    assign bus.mem_aluResult       = res_q;
    assign bus.mem_storeData       = store_q;
    assign bus.mem_dest            = dest_q;
    assign bus.mem_DMMemWrite      = dm_q;
    assign bus.mem_regWrite        = rw_q;
    assign bus.mem_regWriteDataSel = sel_q;
    assign bus.zFlag               = z_q;
    assign bus.cFlag               = c_q;
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: an independent behavioural model predicts each EX/MEM
// result, pushes it to a scoreboard queue, and each test pops and compares after the edge.
module tb_ex_stage;
    typedef struct packed {
        logic [3:0] fn;
        logic [7:0] r1;
        logic [7:0] r2;
        logic [7:0] cd;
        logic [2:0] sc;
        logic [2:0] dest;
        logic [2:0] a1;
        logic [2:0] a2;
        logic       bsel;
        logic       dm;
        logic       rw;
        logic       sel;
        logic       zen;
        logic       cen;
        logic       wbw;
        logic [2:0] wbd;
        logic [7:0] wbdat;
    } instr_t;

    typedef struct packed {
        logic [7:0] res;
        logic [7:0] store;
        logic [2:0] dest;
        logic       dm;
        logic       rw;
        logic       sel;
        logic       z;
        logic       c;
    } exp_t;

    logic   clk;
    logic   rst;
    int     ntest;
    int     nfail;
    exp_t   sb[$];
    exp_t   st;

    ex_stage_if bus_if ();

    ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic instr_t base();
        instr_t i;
        i      = '0;
        i.a1   = 3'd6;
        i.a2   = 3'd7;
        i.dest = 3'd1;
        i.rw   = 1'b1;
        i.zen  = 1'b1;
        i.cen  = 1'b1;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i = instr_t'({$urandom, $urandom, $urandom});
        return i;
    endfunction

    function automatic logic [7:0] fwd(input logic [2:0] ad, input logic [7:0] v, input instr_t i);
        if (st.rw && !st.sel && st.dest == ad) return st.res;
        if (i.wbw && i.wbd == ad) return i.wbdat;
        return v;
    endfunction

    function automatic exp_t predict(input instr_t i);
        exp_t       e;
        logic [7:0] a, b2, b, r, t;
        logic       co, hc;
        int         s;
        a  = fwd(i.a1, i.r1, i);
        b2 = fwd(i.a2, i.r2, i);
        b  = i.bsel ? i.cd : b2;
        co = 1'b0;
        hc = 1'b0;
        r  = a;
        t  = a;
        case (i.fn)
            4'd0: begin s = int'(a) + int'(b); r = 8'(s); co = (s > 255); hc = 1'b1; end
            4'd1: begin s = int'(a) + int'(b) + int'(st.c); r = 8'(s); co = (s > 255); hc = 1'b1; end
            4'd2: begin s = int'(a) - int'(b); r = 8'(s); co = (s < 0); hc = 1'b1; end
            4'd3: begin s = int'(a) - int'(b) - int'(st.c); r = 8'(s); co = (s < 0); hc = 1'b1; end
            4'd4: r = a & b;
            4'd5: r = a | b;
            4'd6: r = a ^ b;
            4'd7: r = a & ~b;
            4'd8: begin
                for (int k = 0; k < int'(i.sc); k++) begin co = t[7]; t = {t[6:0], 1'b0}; end
                r = t; hc = (i.sc != 3'd0);
            end
            4'd9: begin
                for (int k = 0; k < int'(i.sc); k++) begin co = t[0]; t = {1'b0, t[7:1]}; end
                r = t; hc = (i.sc != 3'd0);
            end
            4'd10: begin
                for (int k = 0; k < int'(i.sc); k++) t = {t[6:0], t[7]};
                r = t;
            end
            4'd11: begin
                for (int k = 0; k < int'(i.sc); k++) t = {t[0], t[7:1]};
                r = t;
            end
            4'd12:   r = b;
            default: r = a;
        endcase
        e.res   = r;
        e.store = b2;
        e.dest  = i.dest;
        e.dm    = i.dm;
        e.rw    = i.rw;
        e.sel   = i.sel;
        e.z     = i.zen ? (r == 8'd0) : st.z;
        e.c     = (i.cen && hc) ? co : st.c;
        return e;
    endfunction

    function automatic exp_t sample();
        exp_t a;
        a.res   = bus_if.mem_aluResult;
        a.store = bus_if.mem_storeData;
        a.dest  = bus_if.mem_dest;
        a.dm    = bus_if.mem_DMMemWrite;
        a.rw    = bus_if.mem_regWrite;
        a.sel   = bus_if.mem_regWriteDataSel;
        a.z     = bus_if.zFlag;
        a.c     = bus_if.cFlag;
        return a;
    endfunction

    task automatic apply(input instr_t i);
        bus_if.aluFunction     = i.fn;
        bus_if.r1              = i.r1;
        bus_if.r2              = i.r2;
        bus_if.const_disp      = i.cd;
        bus_if.sc              = i.sc;
        bus_if.dest            = i.dest;
        bus_if.r1Address       = i.a1;
        bus_if.r2Address       = i.a2;
        bus_if.AluInputBSel    = i.bsel;
        bus_if.DMMemWrite      = i.dm;
        bus_if.regWrite        = i.rw;
        bus_if.regWriteDataSel = i.sel;
        bus_if.Zenb            = i.zen;
        bus_if.Cenb            = i.cen;
        bus_if.wb_regWrite     = i.wbw;
        bus_if.wb_dest         = i.wbd;
        bus_if.wb_data         = i.wbdat;
    endtask

    // Drive one instruction, push its prediction, advance one edge, commit the model.
    task automatic issue(input instr_t i);
        exp_t e;
        apply(i);
        bus_if.enb   = 1'b1;
        bus_if.flush = 1'b0;
        e = predict(i);
        sb.push_back(e);
        @(posedge clk);
        #1;
        st = e;
    endtask

    task automatic test_reset();
        exp_t a;
        rst = 1'b1;
        apply('0);
        bus_if.enb   = 1'b1;
        bus_if.flush = 1'b0;
        st = '0;
        repeat (2) @(negedge clk);
        a = sample();
        ntest++;
        if (a !== exp_t'(0)) begin nfail++; $display("FAIL reset_state: got %h want 0", a); end
        rst = 1'b0;
    endtask

    task automatic test_add_adc();
        instr_t i;
        exp_t   e, a;
        i = base(); i.fn = 4'd0; i.r1 = 8'hF0; i.r2 = 8'h20;
        issue(i); e = sb.pop_front(); a = sample();
        ntest++;
        if (a !== e) begin nfail++; $display("FAIL add_model: got %h want %h", a, e); end
        ntest++;
        if (a.res !== 8'h10 || a.c !== 1'b1 || a.z !== 1'b0) begin
            nfail++; $display("FAIL add_f0_20: got res=%h c=%b z=%b want res=10 c=1 z=0", a.res, a.c, a.z);
        end
        i = base(); i.fn = 4'd1; i.r1 = 8'h01; i.r2 = 8'h01;
        issue(i); e = sb.pop_front(); a = sample();
        ntest++;
        if (a !== e || a.res !== 8'h03) begin nfail++; $display("FAIL adc_carry_in: got %h want %h (res 03)", a, e); end
    endtask

    task automatic test_sub();
        instr_t i;
        exp_t   e, a;
        i = base(); i.fn = 4'd2; i.r1 = 8'h05; i.r2 = 8'h05;
        issue(i); e = sb.pop_front(); a = sample();
        ntest++;
        if (a !== e || a.res !== 8'h00 || a.z !== 1'b1 || a.c !== 1'b0) begin
            nfail++; $display("FAIL sub_equal: got %h want %h (res 00 z 1 c 0)", a, e);
        end
        i = base(); i.fn = 4'd2; i.r1 = 8'h03; i.r2 = 8'h05;
        issue(i); e = sb.pop_front(); a = sample();
        ntest++;
        if (a !== e || a.res !== 8'hFE || a.c !== 1'b1 || a.z !== 1'b0) begin
            nfail++; $display("FAIL sub_borrow: got %h want %h (res fe c 1)", a, e);
        end
        i = base(); i.fn = 4'd3; i.r1 = 8'h10; i.r2 = 8'h01;
        issue(i); e = sb.pop_front(); a = sample();
        ntest++;
        if (a !== e || a.res !== 8'h0E) begin nfail++; $display("FAIL sbc_borrow_in: got %h want %h (res 0e)", a, e); end
    endtask

    task automatic test_forwarding();
        instr_t i;
        exp_t   e, a;
        i = base(); i.fn = 4'd0; i.r1 = 8'h11; i.bsel = 1'b1; i.cd = 8'h00; i.dest = 3'd2;
        issue(i); e = sb.pop_front(); a = sample();
        ntest++;
        if (a !== e) begin nfail++; $display("FAIL fwd_setup: got %h want %h", a, e); end
        i = base(); i.fn = 4'd0; i.a1 = 3'd2; i.r1 = 8'h55; i.bsel = 1'b1; i.cd = 8'h00;
        i.a2 = 3'd2; i.r2 = 8'h66; i.wbw = 1'b1; i.wbd = 3'd2; i.wbdat = 8'h22;
        i.dest = 3'd2; i.sel = 1'b1;
        issue(i); e = sb.pop_front(); a = sample();
        ntest++;
        if (a !== e || a.res !== 8'h11 || a.store !== 8'h11) begin
            nfail++; $display("FAIL fwd_mem_priority: got %h want %h (res 11 store 11)", a, e);
        end
        issue(i); e = sb.pop_front(); a = sample();
        ntest++;
        if (a !== e || a.res !== 8'h22 || a.store !== 8'h22) begin
            nfail++; $display("FAIL fwd_load_use_wb: got %h want %h (res 22 store 22)", a, e);
        end
    endtask

    task automatic test_shift_rotate();
        instr_t i;
        exp_t   e, a;
        i = base(); i.fn = 4'd8; i.r1 = 8'h81; i.sc = 3'd1;
        issue(i); e = sb.pop_front(); a = sample();
        ntest++;
        if (a !== e || a.res !== 8'h02 || a.c !== 1'b1) begin nfail++; $display("FAIL shl_81: got %h want %h (res 02 c 1)", a, e); end
        i = base(); i.fn = 4'd11; i.r1 = 8'h01; i.sc = 3'd1; i.zen = 1'b0;
        issue(i); e = sb.pop_front(); a = sample();
        ntest++;
        if (a !== e || a.res !== 8'h80 || a.c !== 1'b1) begin nfail++; $display("FAIL ror_01: got %h want %h (res 80 c 1)", a, e); end
        i = base(); i.fn = 4'd2; i.r1 = 8'h07; i.r2 = 8'h07;
        issue(i); e = sb.pop_front();
        i = base(); i.fn = 4'd8; i.r1 = 8'h81; i.sc = 3'd0;
        issue(i); e = sb.pop_front(); a = sample();
        ntest++;
        if (a !== e || a.res !== 8'h81 || a.c !== 1'b0) begin nfail++; $display("FAIL shl_sc0: got %h want %h (res 81 c 0)", a, e); end
        i = base(); i.fn = 4'd9; i.r1 = 8'h0C; i.sc = 3'd3;
        issue(i); e = sb.pop_front(); a = sample();
        ntest++;
        if (a !== e || a.res !== 8'h01 || a.c !== 1'b1) begin nfail++; $display("FAIL shr_0c_3: got %h want %h (res 01 c 1)", a, e); end
    endtask

    task automatic test_back_to_back();
        instr_t i;
        exp_t   e, a;
        for (int n = 0; n < 200; n++) begin
            i = rand_instr();
            issue(i); e = sb.pop_front(); a = sample();
            ntest++;
            if (a !== e) begin nfail++; $display("FAIL random_%0d: got %h want %h instr %h", n, a, e, i); end
        end
    endtask

    task automatic test_stall_flush();
        instr_t i;
        exp_t   e, a;
        i = base(); i.fn = 4'd2; i.r1 = 8'h01; i.r2 = 8'h02; i.dm = 1'b1;
        issue(i); e = sb.pop_front();
        for (int n = 0; n < 3; n++) begin
            apply(rand_instr());
            bus_if.enb = 1'b0; bus_if.flush = 1'b0;
            @(posedge clk); #1;
            a = sample();
            ntest++;
            if (a !== st) begin nfail++; $display("FAIL stall_hold_%0d: got %h want %h", n, a, st); end
        end
        for (int n = 0; n < 2; n++) begin
            i = base(); i.fn = 4'd2; i.r1 = 8'h40; i.r2 = 8'h40; i.dm = 1'b1;
            issue(i); e = sb.pop_front();
            i = base(); i.fn = 4'd2; i.r1 = 8'h00; i.r2 = 8'h01; i.dm = 1'b1;
            apply(i);
            bus_if.enb = (n == 0); bus_if.flush = 1'b1;
            @(posedge clk); #1;
            a = sample();
            ntest++;
            if (a.rw !== 1'b0 || a.dm !== 1'b0 || a.z !== st.z || a.c !== st.c) begin
                nfail++; $display("FAIL flush_enb%0d: got rw=%b dm=%b z=%b c=%b want rw=0 dm=0 z=%b c=%b",
                                  1 - n, a.rw, a.dm, a.z, a.c, st.z, st.c);
            end
            st.rw = 1'b0;
            st.dm = 1'b0;
        end
        bus_if.flush = 1'b0;
    endtask

    task automatic test_reset_midstream();
        instr_t i;
        exp_t   e, a;
        i = base(); i.fn = 4'd0; i.r1 = 8'hF0; i.r2 = 8'h20; i.dm = 1'b1;
        issue(i); e = sb.pop_front();
        i = base(); i.fn = 4'd5; i.r1 = 8'h5A; i.r2 = 8'hA5;
        apply(i);
        @(negedge clk);
        rst = 1'b1;
        #1;
        a = sample();
        ntest++;
        if (a !== exp_t'(0)) begin nfail++; $display("FAIL reset_async: got %h want 0", a); end
        @(posedge clk); #1;
        a = sample();
        ntest++;
        if (a !== exp_t'(0)) begin nfail++; $display("FAIL reset_held: got %h want 0", a); end
        @(negedge clk);
        rst = 1'b0;
        st  = '0;
        i = base(); i.fn = 4'd1; i.r1 = 8'h01; i.r2 = 8'h01;
        issue(i); e = sb.pop_front(); a = sample();
        ntest++;
        if (a !== e || a.res !== 8'h02 || a.c !== 1'b0) begin nfail++; $display("FAIL reset_recover_adc: got %h want %h (res 02)", a, e); end
    endtask

    initial begin
        ntest = 0;
        nfail = 0;
        test_reset();
        test_add_adc();
        test_sub();
        test_forwarding();
        test_shift_rotate();
        test_back_to_back();
        test_stall_flush();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- enb  in  1  advance enable; 0 = stall, hold all state
- flush  in  1  squash the instruction in EX
- r1, r2  in  8  operand values from the ID/EX register
- const_disp  in  8  immediate/displacement
- sc  in  3  shift/rotate count
- dest  in  3  destination register index
- r1Address, r2Address  in  3  source register indices
- aluFunction  in  4  ALU operation
- AluInputBSel  in  1  ALU B select: 0 = forwarded r2, 1 = const_disp
- DMMemWrite, regWrite, regWriteDataSel  in  1  controls passed downstream; regWriteDataSel=1 means memory data
- Zenb, Cenb  in  1  zero/carry flag update enables
- wb_regWrite  in  1  write-back stage writes a register
- wb_dest  in  3  write-back destination
- wb_data  in  8  write-back value
- mem_aluResult, mem_storeData  out  8  EX/MEM registered ALU result and store data
- mem_dest  out  3  EX/MEM registered destination
- mem_DMMemWrite, mem_regWrite, mem_regWriteDataSel  out  1  EX/MEM registered controls
- zFlag, cFlag  out  1  architectural Z and C flags

Function
REQ-002 Forwarded A SHALL be mem_aluResult when mem_regWrite=1, mem_regWriteDataSel=0 and mem_dest==r1Address; else wb_data when wb_regWrite=1 and wb_dest==r1Address; else r1. EX/MEM has priority.
REQ-003 Forwarded r2 SHALL use the same rule with r2Address; ALU B = const_disp when AluInputBSel=1, else forwarded r2.
REQ-004 ALU SHALL be combinational with 8-bit result; carry-out cout is defined per op:
- 0000 ADD A+B, cout = bit 8
- 0001 ADC A+B+cFlag, cout = bit 8
- 0010 SUB A-B, cout = borrow
- 0011 SBC A-B-cFlag, cout = borrow
- 0100 AND, 0101 OR, 0110 XOR, 0111 A AND NOT B; no cout
- 1000 SHL A by sc, cout = last bit shifted out
- 1001 SHR A by sc (zero fill), cout = last bit shifted out
- 1010 ROL, 1011 ROR A by sc; no cout
- 1100 pass B; no cout
- 1101-1111 pass A; no cout
REQ-005 Shifts with sc=0 SHALL return A unchanged and define no cout.
REQ-006 On a rising edge with enb=1 and flush=0, the block SHALL capture:
- result into mem_aluResult
- forwarded r2 into mem_storeData
- dest into mem_dest
- the three controls into the mem_* control outputs
REQ-007 In that same edge, zFlag SHALL load (result==0) if Zenb=1, and cFlag SHALL load cout if Cenb=1 and the op defines cout; otherwise each flag holds.
REQ-008 On a rising edge with flush=1, the block SHALL clear mem_regWrite and mem_DMMemWrite to 0 and leave both flags unchanged, regardless of enb; other mem_* fields are don't-care.
REQ-009 With enb=0 and flush=0, every register SHALL hold its value.
REQ-010 Latency SHALL be one cycle from ID/EX values to mem_* outputs; flag effects are visible to the next instruction's ADC/SBC in the following cycle.
REQ-011 Load-use hazards (mem_regWriteDataSel=1) SHALL NOT be forwarded from EX/MEM; stalling is the hazard unit's job, and WB forwarding still applies.

Reset
REQ-012 While rst=1, all mem_* outputs, zFlag and cFlag SHALL be 0 immediately, independent of clk.
REQ-013 Deassertion of rst SHALL give normal operation starting at the next rising edge; an operation in flight at reset is discarded.

Verification
REQ-014 Scenario: ADD r1=0xF0, r2=0x20, Cenb=Zenb=1 -> mem_aluResult=0x10, cFlag=1, zFlag=0; then ADC 0x01+0x01 -> 0x03.
REQ-015 Scenario: SUB 0x05-0x05 with Zenb=1, Cenb=1 -> result 0x00, zFlag=1, cFlag=0; SUB 0x03-0x05 -> 0xFE, cFlag=1.
REQ-016 Scenario: mem_dest=2 with mem_regWrite=1 (0x11) and wb_dest=2 with wb_regWrite=1 (0x22), r1Address=2, ADD with B=0 -> mem_aluResult=0x11; set mem_regWriteDataSel=1 -> 0x22.
REQ-017 Scenario: SHL A=0x81, sc=1, Cenb=1 -> 0x02, cFlag=1; ROR A=0x01, sc=1 -> 0x80, cFlag unchanged.
REQ-018 Scenario: enb=0 for 3 cycles -> outputs and flags hold; flush=1 -> mem_regWrite=0, mem_DMMemWrite=0, flags unchanged.
REQ-019 Scenario: assert rst between clock edges mid-stream -> all outputs 0 before the next edge.
